// File: rtl/row_accum.sv
// Row accumulator: sums CHUNKS consecutive dot8 partial results into one row sum,
// tags it with its row index and queues it in a small FIFO that absorbs consumer stalls.
module row_accum #(
  parameter int unsigned IWIDTH = 32,
  parameter int unsigned OWIDTH = 32,
  parameter int unsigned CHUNKS = 4,
  parameter int unsigned ROWS   = 8,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ivalid,
  input  logic [IWIDTH-1:0] idata,
  output logic              ovalid,
  input  logic              oready,
  output logic [OWIDTH-1:0] odata,
  output logic [RW-1:0]     orow,
  output logic              olast,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]     chunk_cnt_q, chunk_cnt_d;
  logic [RW-1:0]     row_idx_q, row_idx_d;
  logic [OWIDTH-1:0] acc_q, acc_d;
  logic              overflow_q, overflow_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;

  logic [OWIDTH-1:0] mem_data_q [DEPTH];
  logic [RW-1:0]     mem_row_q  [DEPTH];

  logic signed [IWIDTH-1:0] idata_s;
  logic [OWIDTH-1:0]        idata_ext;
  logic [OWIDTH-1:0]        sum_n;
  logic                     last_chunk;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     fifo_we;

  // Signed cast so the size cast replicates the sign bit.
  assign idata_s    = idata;
  assign idata_ext  = OWIDTH'(idata_s);
  assign sum_n      = ((chunk_cnt_q == '0) ? '0 : acc_q) + idata_ext;
  assign last_chunk = (chunk_cnt_q == CW'(CHUNKS - 1));

  assign full    = (count_q == (PW + 1)'(DEPTH));
  assign ovalid  = (count_q != '0);
  assign push    = ivalid && last_chunk;
  assign pop     = ovalid && oready;
  // A pop on a full FIFO frees the slot the push lands in.
  assign fifo_we = push && (!full || pop);

  always_comb begin
    chunk_cnt_d = chunk_cnt_q;
    row_idx_d   = row_idx_q;
    acc_d       = acc_q;
    overflow_d  = overflow_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (ivalid) begin
      if (last_chunk) begin
        chunk_cnt_d = '0;
        row_idx_d   = (row_idx_q == RW'(ROWS - 1)) ? '0 : row_idx_q + RW'(1);
      end else begin
        chunk_cnt_d = chunk_cnt_q + CW'(1);
        acc_d       = sum_n;
      end
    end

    if (push && !fifo_we) begin
      overflow_d = 1'b1;
    end
    if (fifo_we) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({fifo_we, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chunk_cnt_q <= '0;
      row_idx_q   <= '0;
      acc_q       <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      chunk_cnt_q <= chunk_cnt_d;
      row_idx_q   <= row_idx_d;
      acc_q       <= acc_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_data_q[i] <= '0;
        mem_row_q[i]  <= '0;
      end
    end else if (fifo_we) begin
      mem_data_q[wr_ptr_q] <= sum_n;
      mem_row_q[wr_ptr_q]  <= row_idx_q;
    end
  end

  // Head fields read as zero while empty so idle outputs are quiet.
  assign odata    = ovalid ? mem_data_q[rd_ptr_q] : '0;
  assign orow     = ovalid ? mem_row_q[rd_ptr_q] : '0;
  assign olast    = ovalid && (mem_row_q[rd_ptr_q] == RW'(ROWS - 1));
  assign overflow = overflow_q;
  assign busy     = (chunk_cnt_q != '0);

endmodule

// File: tb/tb_row_accum.sv
// Directed bench for row_accum: inputs change and outputs are checked on the falling edge.
module tb_row_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        ivalid;
  logic [31:0] idata;
  logic        ovalid;
  logic        oready;
  logic [31:0] odata;
  logic [2:0]  orow;
  logic        olast;
  logic        overflow;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  row_accum #(
    .IWIDTH(32), .OWIDTH(32), .CHUNKS(4), .ROWS(8), .DEPTH(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ivalid  (ivalid),
    .idata   (idata),
    .ovalid  (ovalid),
    .oready  (oready),
    .odata   (odata),
    .orow    (orow),
    .olast   (olast),
    .overflow(overflow),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic feed(input logic [31:0] d);
    ivalid = 1'b1;
    idata  = d;
    @(negedge clk);
    ivalid = 1'b0;
  endtask

  task automatic feed_row(input logic [31:0] d);
    for (int i = 0; i < 4; i++) feed(d);
  endtask

  task automatic do_reset();
    ivalid = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
  endtask

  task automatic test_reset();
    oready = 1'b0;
    idata  = '0;
    @(negedge clk);
    do_reset();
    n_cmp++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL reset_ovalid got %b want 0", ovalid); end
    n_cmp++; if (odata !== 32'd0) begin n_err++; $display("FAIL reset_odata got %h want 0", odata); end
    n_cmp++; if (orow !== 3'd0) begin n_err++; $display("FAIL reset_orow got %0d want 0", orow); end
    n_cmp++; if (olast !== 1'b0) begin n_err++; $display("FAIL reset_olast got %b want 0", olast); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_single_row();
    oready = 1'b1;
    feed_row(32'd169);
    n_cmp++; if (ovalid !== 1'b1) begin n_err++; $display("FAIL single_ovalid got %b want 1", ovalid); end
    n_cmp++; if (odata !== 32'd676) begin n_err++; $display("FAIL single_odata got %0d want 676", odata); end
    n_cmp++; if (orow !== 3'd0) begin n_err++; $display("FAIL single_orow got %0d want 0", orow); end
    n_cmp++; if (olast !== 1'b0) begin n_err++; $display("FAIL single_olast got %b want 0", olast); end
    step();
    n_cmp++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL single_drained got %b want 0", ovalid); end
  endtask

  task automatic test_signed_wrap();
    oready = 1'b1;
    feed(-32'd5); feed(32'd3); feed(-32'd10); feed(32'd2);
    n_cmp++; if (odata !== 32'hFFFF_FFF6 || ovalid !== 1'b1) begin
      n_err++; $display("FAIL signed_sum got %h/%b want fffffff6/1", odata, ovalid);
    end
    step();
    feed(32'h7FFF_FFFF); feed(32'd1); feed(32'd0); feed(32'd0);
    n_cmp++; if (odata !== 32'h8000_0000 || ovalid !== 1'b1) begin
      n_err++; $display("FAIL wrap_sum got %h/%b want 80000000/1", odata, ovalid);
    end
    step();
  endtask

  task automatic test_overflow();
    do_reset();
    oready = 1'b0;
    for (int r = 0; r < 4; r++) feed_row(32'(r + 1));
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b want 0", overflow); end
    feed_row(32'd5);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", overflow); end
    step(); step();
    n_cmp++; if (odata !== 32'd4 || orow !== 3'd0) begin
      n_err++; $display("FAIL ovf_head_stable got %0d/%0d want 4/0", odata, orow);
    end
    oready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (ovalid !== 1'b1 || odata !== 32'(4 * (k + 1)) || orow !== 3'(k)) begin
        n_err++; $display("FAIL ovf_drain%0d got %b/%0d/%0d want 1/%0d/%0d", k, ovalid, odata, orow, 4 * (k + 1), k);
      end
      step();
    end
    n_cmp++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got %b want 0", ovalid); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    // The dropped row still consumed index 4, so the next one is row 5.
    feed_row(32'd7);
    n_cmp++; if (ovalid !== 1'b1 || odata !== 32'd28 || orow !== 3'd5) begin
      n_err++; $display("FAIL ovf_next_row got %b/%0d/%0d want 1/28/5", ovalid, odata, orow);
    end
    step();
  endtask

  task automatic test_row_wrap();
    do_reset();
    oready = 1'b1;
    for (int r = 0; r < 9; r++) begin
      feed_row(32'd1);
      n_cmp++; if (ovalid !== 1'b1 || odata !== 32'd4 || orow !== 3'(r % 8) || olast !== (r % 8 == 7)) begin
        n_err++; $display("FAIL wrap_row%0d got %b/%0d/%0d/%b want 1/4/%0d/%b", r, ovalid, odata, orow, olast, r % 8, r % 8 == 7);
      end
    end
    step();
    n_cmp++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL wrap_empty got %b want 0", ovalid); end
  endtask

  task automatic test_reset_mid_row();
    do_reset();
    oready = 1'b1;
    feed(32'd100);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy got %b want 1", busy); end
    feed(32'd100);
    do_reset();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy_clr got %b want 0", busy); end
    feed_row(32'd1);
    n_cmp++; if (ovalid !== 1'b1 || odata !== 32'd4 || orow !== 3'd0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL midrst_out got %b/%0d/%0d/%b want 1/4/0/0", ovalid, odata, orow, overflow);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [6:0] pat;
    do_reset();
    oready = 1'b1;
    pat    = 7'b1001011;
    for (int i = 6; i >= 0; i--) begin
      ivalid = pat[i];
      idata  = 32'd2;
      step();
    end
    ivalid = 1'b0;
    n_cmp++; if (ovalid !== 1'b1 || odata !== 32'd8 || orow !== 3'd0) begin
      n_err++; $display("FAIL bubble_sum got %b/%0d/%0d want 1/8/0", ovalid, odata, orow);
    end
    step();
    oready = 1'b0;
    for (int r = 1; r <= 4; r++) feed_row(32'(r));
    feed(32'd5); feed(32'd5); feed(32'd5);
    // Final chunk lands in the same cycle the full FIFO pops.
    ivalid = 1'b1; idata = 32'd5; oready = 1'b1;
    step();
    ivalid = 1'b0; oready = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pushpop_overflow got %b want 0", overflow); end
    oready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (ovalid !== 1'b1 || odata !== 32'(4 * (k + 2)) || orow !== 3'(k + 2)) begin
        n_err++; $display("FAIL pushpop_drain%0d got %b/%0d/%0d want 1/%0d/%0d", k, ovalid, odata, orow, 4 * (k + 2), k + 2);
      end
      step();
    end
    n_cmp++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL pushpop_empty got %b want 0", ovalid); end
  endtask

  initial begin
    rst    = 1'b1;
    ivalid = 1'b0;
    idata  = '0;
    oready = 1'b0;
    test_reset();
    test_single_row();
    test_signed_wrap();
    test_overflow();
    test_row_wrap();
    test_reset_mid_row();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
